// File: rtl/snake_body_buffer_if.sv
// Bus between the snake movement/colour logic and the segment ring buffer.
// The master drives movement and pixel queries; the slave returns hit flags, length and status.
interface snake_body_buffer_if #(
    parameter int MAX_LEN = 32,
    parameter int COORD_W = 9
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic               step;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic               grow;
    logic               clear;
    logic [7:0]         pixel_x;
    logic [7:0]         pixel_y;

    logic               hit;
    logic               head_hit;
    logic [LEN_W-1:0]   len;
    logic               full;
    logic               collision;
    // Internal state exposed for observation: pending growth and head pointer.
    logic [LEN_W-1:0]   pend;
    logic [IDX_W-1:0]   hp;

    modport master (
        output step, head_x, head_y, grow, clear, pixel_x, pixel_y,
        input  hit, head_hit, len, full, collision, pend, hp
    );

    modport slave (
        input  step, head_x, head_y, grow, clear, pixel_x, pixel_y,
        output hit, head_hit, len, full, collision, pend, hp
    );
endinterface

// File: rtl/snake_body_buffer.sv
// Ring buffer of snake segment coordinates: captures the head on each movement tick,
// tracks length with pending growth, flags self-collision and answers a registered pixel-hit query.
module snake_body_buffer #(
    parameter int MAX_LEN  = 32,
    parameter int COORD_W  = 9,
    parameter int INIT_LEN = 3,
    parameter int SEG_HALF = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    snake_body_buffer_if.slave   sb
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CW    = COORD_W + 2;
    localparam logic [LEN_W-1:0]     MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]     INIT_LEN_L = LEN_W'(INIT_LEN);
    localparam logic signed [CW-1:0] HALF_S     = CW'(SEG_HALF);

    logic [COORD_W-1:0] r_seg_x [MAX_LEN];
    logic [COORD_W-1:0] r_seg_y [MAX_LEN];
    logic [IDX_W-1:0]   r_hp;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_pend;
    logic               r_collision;
    logic               r_hit;
    logic               r_head_hit;

    logic [LEN_W-1:0]   w_g;
    logic               w_accept;
    logic               w_grows;
    logic [LEN_W-1:0]   w_lim;
    logic [IDX_W-1:0]   w_hp_next;
    logic [IDX_W-1:0]   w_age;
    logic               w_match;
    logic               w_hit;
    logic               w_head_hit;

    // Signed distance test so a segment at 0 never reaches pixel 255 through wrap-around.
    function automatic logic f_near(input logic [7:0] p, input logic [COORD_W-1:0] s);
        logic signed [CW-1:0] d;
        d = $signed(CW'(p)) - $signed(CW'(s));
        return (d >= -HALF_S) && (d <= HALF_S);
    endfunction

    always_comb begin
        w_g       = (r_pend == MAX_LEN_L) ? MAX_LEN_L : r_pend + LEN_W'(sb.grow);
        w_accept  = sb.step && ((r_len == '0) ||
                                (sb.head_x != r_seg_x[r_hp]) ||
                                (sb.head_y != r_seg_y[r_hp]));
        w_grows   = (w_g != '0) && (r_len != MAX_LEN_L);
        // When length holds, the oldest segment vacates on this step and cannot be hit.
        w_lim     = w_grows ? r_len : r_len - LEN_W'(1);
        w_hp_next = r_hp + IDX_W'(1);
        w_age     = '0;
        w_match   = 1'b0;
        w_hit     = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_age = r_hp - IDX_W'(i);
            if ((LEN_W'(w_age) < w_lim) &&
                (r_seg_x[i] == sb.head_x) && (r_seg_y[i] == sb.head_y))
                w_match = 1'b1;
            if ((LEN_W'(w_age) < r_len) &&
                f_near(sb.pixel_x, r_seg_x[i]) && f_near(sb.pixel_y, r_seg_y[i]))
                w_hit = 1'b1;
        end
        w_match    = w_match && (r_len != '0);
        w_head_hit = (r_len != '0) &&
                     f_near(sb.pixel_x, r_seg_x[r_hp]) && f_near(sb.pixel_y, r_seg_y[r_hp]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hp        <= '0;
            r_len       <= '0;
            r_pend      <= INIT_LEN_L;
            r_collision <= 1'b0;
            r_hit       <= 1'b0;
            r_head_hit  <= 1'b0;
        end else if (sb.clear) begin
            r_hp        <= '0;
            r_len       <= '0;
            r_pend      <= INIT_LEN_L;
            r_collision <= 1'b0;
            r_hit       <= 1'b0;
            r_head_hit  <= 1'b0;
        end else begin
            r_hit      <= w_hit;
            r_head_hit <= w_head_hit;
            if (w_accept) begin
                r_hp <= w_hp_next;
                if (w_grows) begin
                    r_len  <= r_len + LEN_W'(1);
                    r_pend <= w_g - LEN_W'(1);
                end else begin
                    r_pend <= w_g;
                end
                if (w_match)
                    r_collision <= 1'b1;
            end else begin
                r_pend <= w_g;
            end
        end
    end

    // Segment contents are don't-care after reset, so the ring carries no reset.
    always_ff @(posedge clk) begin
        if (!sb.clear && w_accept) begin
            r_seg_x[w_hp_next] <= sb.head_x;
            r_seg_y[w_hp_next] <= sb.head_y;
        end
    end

    assign sb.hit       = r_hit;
    assign sb.head_hit  = r_head_hit;
    assign sb.len       = r_len;
    assign sb.full      = (r_len == MAX_LEN_L);
    assign sb.collision = r_collision;
    assign sb.pend      = r_pend;
    assign sb.hp        = r_hp;
endmodule

// File: tb/tb_snake_body_buffer.sv
// Bench for snake_body_buffer: queue-based body model checked every cycle, plus directed literal checks.
module tb_snake_body_buffer;
    localparam int MAX_LEN  = 32;
    localparam int COORD_W  = 9;
    localparam int INIT_LEN = 3;
    localparam int SEG_HALF = 1;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    snake_body_buffer_if #(.MAX_LEN(MAX_LEN), .COORD_W(COORD_W)) sb ();

    snake_body_buffer #(
        .MAX_LEN(MAX_LEN), .COORD_W(COORD_W), .INIT_LEN(INIT_LEN), .SEG_HALF(SEG_HALF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sb(sb.slave)
    );

    always #5 clk = ~clk;

    // Model: body as queues with the newest segment at index 0.
    int m_bx[$];
    int m_by[$];
    int m_pend     = INIT_LEN;
    bit m_coll     = 1'b0;
    bit m_hit      = 1'b0;
    bit m_head_hit = 1'b0;

    function automatic bit near(int p, int s);
        return ((p - s) <= SEG_HALF) && ((s - p) <= SEG_HALF);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || sb.clear) begin
            m_bx.delete();
            m_by.delete();
            m_pend     = INIT_LEN;
            m_coll     = 1'b0;
            m_hit      = 1'b0;
            m_head_hit = 1'b0;
        end else begin
            int  g;
            int  lim;
            bit  acc;
            bit  grows;
            int  hx;
            int  hy;
            hx = int'(sb.head_x);
            hy = int'(sb.head_y);
            m_hit = 1'b0;
            for (int k = 0; k < m_bx.size(); k++)
                if (near(int'(sb.pixel_x), m_bx[k]) && near(int'(sb.pixel_y), m_by[k]))
                    m_hit = 1'b1;
            m_head_hit = (m_bx.size() > 0) &&
                         near(int'(sb.pixel_x), m_bx[0]) && near(int'(sb.pixel_y), m_by[0]);
            g = m_pend + int'(sb.grow);
            if (g > MAX_LEN) g = MAX_LEN;
            acc = sb.step && ((m_bx.size() == 0) || (hx != m_bx[0]) || (hy != m_by[0]));
            if (acc) begin
                grows = (g > 0) && (m_bx.size() < MAX_LEN);
                lim   = grows ? m_bx.size() : m_bx.size() - 1;
                for (int k = 0; k < lim; k++)
                    if ((m_bx[k] == hx) && (m_by[k] == hy))
                        m_coll = 1'b1;
                m_bx.push_front(hx);
                m_by.push_front(hy);
                if (grows) begin
                    m_pend = g - 1;
                end else begin
                    void'(m_bx.pop_back());
                    void'(m_by.pop_back());
                    m_pend = g;
                end
            end else begin
                m_pend = g;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("len",       32'(sb.len),       32'(m_bx.size()));
        chk("full",      32'(sb.full),      32'(m_bx.size() == MAX_LEN));
        chk("collision", 32'(sb.collision), 32'(m_coll));
        chk("hit",       32'(sb.hit),       32'(m_hit));
        chk("head_hit",  32'(sb.head_hit),  32'(m_head_hit));
        chk("pend",      32'(sb.pend),      32'(m_pend));
    end

    task automatic step_to(input int x, input int y, input bit gr);
        sb.step   = 1'b1;
        sb.head_x = COORD_W'(x);
        sb.head_y = COORD_W'(y);
        sb.grow   = gr;
        @(posedge clk); #1;
        sb.step = 1'b0;
        sb.grow = 1'b0;
    endtask

    task automatic query(input int x, input int y);
        sb.pixel_x = 8'(x);
        sb.pixel_y = 8'(y);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        sb.clear = 1'b1;
        @(posedge clk); #1;
        sb.clear = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        sb.step    = 1'b0;
        sb.grow    = 1'b0;
        sb.clear   = 1'b0;
        sb.head_x  = '0;
        sb.head_y  = '0;
        sb.pixel_x = 8'd200;
        sb.pixel_y = 8'd200;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("lit_reset_len", 32'(sb.len), 0);
        chk("lit_reset_pend", 32'(sb.pend), 3);
        chk("lit_reset_hp", 32'(sb.hp), 0);

        // Initial growth of three, then a length-holding step.
        step_to(40, 40, 0);
        chk("lit_len1", 32'(sb.len), 1);
        step_to(41, 40, 0);
        step_to(42, 40, 0);
        chk("lit_len3", 32'(sb.len), 3);
        step_to(43, 40, 0);
        chk("lit_len3_hold", 32'(sb.len), 3);
        chk("lit_coll0", 32'(sb.collision), 0);
        query(39, 40);
        chk("lit_q39_40", 32'(sb.hit), 0);
        query(41, 39);
        chk("lit_q41_39", 32'(sb.hit), 1);
        query(44, 41);
        chk("lit_q44_41_hit", 32'(sb.hit), 1);
        chk("lit_q44_41_head", 32'(sb.head_hit), 1);
        chk("lit_hp4", 32'(sb.hp), 4);

        // Stationary head: ignored, but grow still accumulates.
        step_to(43, 40, 0);
        step_to(43, 40, 1);
        step_to(43, 40, 0);
        step_to(43, 40, 1);
        step_to(43, 40, 0);
        chk("lit_stat_len", 32'(sb.len), 3);
        chk("lit_stat_hp", 32'(sb.hp), 4);
        chk("lit_stat_pend", 32'(sb.pend), 2);
        step_to(44, 40, 0);
        chk("lit_move_len4", 32'(sb.len), 4);
        chk("lit_move_pend1", 32'(sb.pend), 1);

        // Saturation at MAX_LEN with growth retained.
        for (int i = 0; i < 40; i++) step_to(45 + i, 40, 1);
        chk("lit_sat_len", 32'(sb.len), 32);
        chk("lit_sat_full", 32'(sb.full), 1);
        chk("lit_sat_pend", 32'(sb.pend), 13);
        chk("lit_sat_hp", 32'(sb.hp), 13);
        query(45, 40);
        chk("lit_old_seg", 32'(sb.hit), 0);
        query(51, 40);
        chk("lit_past_tail", 32'(sb.hit), 0);
        query(52, 40);
        chk("lit_tail_edge", 32'(sb.hit), 1);

        // Length-4 square loop onto the vacating tail: no collision.
        pulse_clear();
        chk("lit_clear_len", 32'(sb.len), 0);
        step_to(10, 10, 1);
        step_to(11, 10, 0);
        step_to(11, 11, 0);
        step_to(10, 11, 0);
        chk("lit_sq4_len", 32'(sb.len), 4);
        chk("lit_sq4_pend", 32'(sb.pend), 0);
        for (int r = 0; r < 2; r++) begin
            step_to(10, 10, 0);
            step_to(11, 10, 0);
            step_to(11, 11, 0);
            step_to(10, 11, 0);
        end
        chk("lit_sq4_coll", 32'(sb.collision), 0);

        // Length-5 loop: head lands on a live segment.
        pulse_clear();
        step_to(9, 10, 1);
        step_to(10, 10, 1);
        step_to(11, 10, 0);
        step_to(11, 11, 0);
        step_to(10, 11, 0);
        chk("lit_sq5_len", 32'(sb.len), 5);
        chk("lit_sq5_coll0", 32'(sb.collision), 0);
        step_to(10, 10, 0);
        chk("lit_sq5_coll1", 32'(sb.collision), 1);
        step_to(10, 9, 0);
        step_to(11, 9, 0);
        chk("lit_coll_sticky", 32'(sb.collision), 1);
        query(11, 9);
        chk("lit_pre_rst_hit", 32'(sb.hit), 1);

        // Asynchronous reset in the middle of a cycle.
        #2 reset_n = 1'b0;
        #1;
        chk("lit_arst_len", 32'(sb.len), 0);
        chk("lit_arst_coll", 32'(sb.collision), 0);
        chk("lit_arst_hit", 32'(sb.hit), 0);
        chk("lit_arst_head", 32'(sb.head_hit), 0);
        chk("lit_arst_pend", 32'(sb.pend), 3);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // Segment at the origin: no wrap to the far edge.
        step_to(0, 0, 0);
        query(255, 0);
        chk("lit_q255_0", 32'(sb.hit), 0);
        query(0, 63);
        chk("lit_q0_63", 32'(sb.hit), 0);
        query(1, 1);
        chk("lit_q1_1", 32'(sb.hit), 1);
        query(0, 0);
        chk("lit_q0_0_head", 32'(sb.head_hit), 1);

        // Clear together with step and grow: clear wins.
        sb.clear  = 1'b1;
        sb.step   = 1'b1;
        sb.grow   = 1'b1;
        sb.head_x = COORD_W'(20);
        sb.head_y = COORD_W'(20);
        @(posedge clk); #1;
        sb.clear = 1'b0;
        sb.step  = 1'b0;
        sb.grow  = 1'b0;
        chk("lit_clr_len", 32'(sb.len), 0);
        chk("lit_clr_coll", 32'(sb.collision), 0);
        chk("lit_clr_hit", 32'(sb.hit), 0);
        chk("lit_clr_pend", 32'(sb.pend), 3);
        chk("lit_clr_hp", 32'(sb.hp), 0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
